// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned MAX_DATA_STREAK_DEFAULT = 4;
    localparam int unsigned ADDR_W_DEFAULT          = 32;
    localparam int unsigned DATA_W_DEFAULT          = 32;
    // Wide enough for the largest legal streak limit (15)
    localparam int unsigned STREAK_W                = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_t;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } arb_src_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Split instruction/data request bus plus the shared single-port memory bus.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MBE_W = DATA_W / 8;

    logic              inst_read;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_resp;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_read;
    logic              data_write;
    logic [MBE_W-1:0]  data_mbe;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_resp;
    logic [DATA_W-1:0] data_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MBE_W-1:0]  mem_mbe;
    logic              mem_resp;
    logic [DATA_W-1:0] mem_rdata;

    // Datapath and memory model side
    modport master (
        output inst_read, inst_addr,
        input  inst_resp, inst_rdata,
        output data_read, data_write, data_mbe, data_addr, data_wdata,
        input  data_resp, data_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_mbe,
        output mem_resp, mem_rdata
    );

    // Arbiter side
    modport slave (
        input  inst_read, inst_addr,
        output inst_resp, inst_rdata,
        input  data_read, data_write, data_mbe, data_addr, data_wdata,
        output data_resp, data_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_mbe,
        input  mem_resp, mem_rdata
    );

endinterface

// File: rtl/arb_req_reg.sv
// Latched request (source, op, address, write data, byte enables) for the
// transaction currently owning the shared memory port.
module arb_req_reg
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  arb_src_t              next_src,
    input  arb_op_t               next_op,
    input  logic [ADDR_W-1:0]     next_addr,
    input  logic [DATA_W-1:0]     next_wdata,
    input  logic [DATA_W/8-1:0]   next_mbe,
    output arb_src_t              src,
    output arb_op_t               op,
    output logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   mbe
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src   <= SRC_INST;
            op    <= OP_READ;
            addr  <= '0;
            wdata <= '0;
            mbe   <= '0;
        end else if (load) begin
            src   <= next_src;
            op    <= next_op;
            addr  <= next_addr;
            wdata <= next_wdata;
            mbe   <= next_mbe;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data requests onto one shared memory port,
// with a bounded data streak so a waiting instruction fetch cannot starve.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = MAX_DATA_STREAK_DEFAULT,
    parameter int unsigned ADDR_W          = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W          = DATA_W_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned MBE_W = DATA_W / 8;

    arb_state_t          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                inst_resp_q, inst_resp_d;
    logic                data_resp_q, data_resp_d;
    logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;

    logic                load;
    arb_src_t            next_src, req_src;
    arb_op_t             next_op, req_op;
    logic [ADDR_W-1:0]   next_addr, req_addr;
    logic [DATA_W-1:0]   next_wdata, req_wdata;
    logic [MBE_W-1:0]    next_mbe, req_mbe;
    logic                data_req;
    logic                streak_full;

    assign data_req    = bus.data_read | bus.data_write;
    assign streak_full = (streak_q == STREAK_W'(MAX_DATA_STREAK));

    arb_req_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .next_src   (next_src),
        .next_op    (next_op),
        .next_addr  (next_addr),
        .next_wdata (next_wdata),
        .next_mbe   (next_mbe),
        .src        (req_src),
        .op         (req_op),
        .addr       (req_addr),
        .wdata      (req_wdata),
        .mbe        (req_mbe)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            streak_q     <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            inst_resp_q  <= 1'b0;
            data_resp_q  <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            inst_resp_q  <= inst_resp_d;
            data_resp_q  <= data_resp_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // Grant, shared-port strobe and response sequencing
    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        inst_resp_d  = 1'b0;
        data_resp_d  = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        load         = 1'b0;
        next_src     = SRC_INST;
        next_op      = OP_READ;
        next_addr    = bus.inst_addr;
        next_wdata   = '0;
        next_mbe     = '0;

        case (state_q)
            IDLE: begin
                if (data_req && !(bus.inst_read && streak_full)) begin
                    load        = 1'b1;
                    next_src    = SRC_DATA;
                    next_op     = bus.data_write ? OP_WRITE : OP_READ;
                    next_addr   = bus.data_addr;
                    next_wdata  = bus.data_wdata;
                    next_mbe    = bus.data_mbe;
                    mem_read_d  = !bus.data_write;
                    mem_write_d = bus.data_write;
                    // streak_full is false here whenever inst_read is set
                    if (bus.inst_read) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                    state_d     = BUSY_D;
                end else if (bus.inst_read) begin
                    load        = 1'b1;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    streak_d    = '0;
                    state_d     = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = RESP;
                    if (req_src == SRC_INST) begin
                        inst_resp_d  = 1'b1;
                        inst_rdata_d = bus.mem_rdata;
                    end else begin
                        data_resp_d = 1'b1;
                        if (req_op == OP_READ) begin
                            data_rdata_d = bus.mem_rdata;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.inst_resp  = inst_resp_q;
    assign bus.inst_rdata = inst_rdata_q;
    assign bus.data_resp  = data_resp_q;
    assign bus.data_rdata = data_rdata_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = req_addr;
    assign bus.mem_wdata  = req_wdata;
    assign bus.mem_mbe    = req_mbe;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected memory
// transactions and port responses; independent monitors pop and compare.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .MAX_DATA_STREAK (4),
        .ADDR_W          (32),
        .DATA_W          (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mbe;
    } mem_exp_t;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
    } resp_exp_t;

    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];

    int checks = 0;
    int errors = 0;
    int mem_wait = 0;
    logic [31:0] exp_d_rdata = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0000_0060) return 32'h00A0_0093;
        return 32'hA5A5_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_mem(input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] m);
        mem_exp_t e;
        e.is_write = w; e.addr = a; e.wdata = wd; e.mbe = m;
        mem_q.push_back(e);
    endtask

    task automatic exp_resp(input logic is_data, input logic [31:0] rd);
        resp_exp_t e;
        e.is_data = is_data; e.rdata = rd;
        resp_q.push_back(e);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    // Returns at posedge+3 of the cycle in which the nth response on the port is seen
    task automatic wait_resp(input logic is_data, input int nth);
        int seen = 0;
        for (int c = 0; c < 200 && seen < nth; c++) begin
            @(posedge clk);
            #3;
            if (is_data ? bus.data_resp : bus.inst_resp) seen++;
        end
        if (seen < nth) begin
            checks++;
            errors++;
            $display("FAIL wait_resp timeout: got %0d responses expected %0d", seen, nth);
        end
    endtask

    // Memory model: respond after mem_wait extra strobe cycles
    initial begin
        int cnt = 0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if ((bus.mem_read || bus.mem_write) && !bus.mem_resp) begin
                if (cnt >= mem_wait) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = mem_f(bus.mem_addr);
                    cnt = 0;
                end else begin
                    bus.mem_resp  = 1'b0;
                    bus.mem_rdata = 32'hBAD0_0000 | 32'(cnt);
                    cnt++;
                end
            end else begin
                bus.mem_resp  = 1'b0;
                bus.mem_rdata = 32'hBAD0_FFFF;
                cnt = 0;
            end
        end
    end

    // Shared-port monitor
    initial begin
        logic     prev_strobe = 1'b0;
        logic     have_cur = 1'b0;
        mem_exp_t cur;
        forever begin
            @(posedge clk);
            #2;
            if (bus.mem_read && bus.mem_write) begin
                checks++;
                errors++;
                $display("FAIL dual_strobe: got read=1 write=1 expected at most one");
            end
            if ((bus.mem_read || bus.mem_write) && !prev_strobe) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    have_cur = 1'b0;
                    $display("FAIL unexpected_mem_txn: got addr 0x%08h expected none", bus.mem_addr);
                end else begin
                    cur = mem_q.pop_front();
                    have_cur = 1'b1;
                end
            end
            if ((bus.mem_read || bus.mem_write) && have_cur) begin
                check("mem_write", 32'(bus.mem_write), 32'(cur.is_write));
                check("mem_addr", bus.mem_addr, cur.addr);
                if (cur.is_write) begin
                    check("mem_wdata", bus.mem_wdata, cur.wdata);
                    check("mem_mbe", 32'(bus.mem_mbe), 32'(cur.mbe));
                end
            end
            prev_strobe = bus.mem_read || bus.mem_write;
        end
    end

    // Port response monitor
    initial begin
        logic      prev_mem_resp = 1'b0;
        logic      prev_any = 1'b0;
        resp_exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (bus.inst_resp && bus.data_resp) begin
                checks++;
                errors++;
                $display("FAIL dual_resp: got inst_resp=1 data_resp=1 expected one");
            end
            if (bus.inst_resp || bus.data_resp) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got inst=%0b data=%0b expected none",
                             bus.inst_resp, bus.data_resp);
                end else begin
                    e = resp_q.pop_front();
                    check("resp_port", 32'(bus.data_resp), 32'(e.is_data));
                    check("resp_rdata", e.is_data ? bus.data_rdata : bus.inst_rdata, e.rdata);
                    check("resp_after_mem_resp", 32'(prev_mem_resp), 32'd1);
                    check("resp_single_pulse", 32'(prev_any), 32'd0);
                end
            end
            prev_mem_resp = bus.mem_resp;
            prev_any      = bus.inst_resp || bus.data_resp;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_inst_resp"},  32'(bus.inst_resp), 32'd0);
        check({tag, "_data_resp"},  32'(bus.data_resp), 32'd0);
        check({tag, "_mem_read"},   32'(bus.mem_read), 32'd0);
        check({tag, "_mem_write"},  32'(bus.mem_write), 32'd0);
        check({tag, "_mem_addr"},   bus.mem_addr, 32'd0);
        check({tag, "_mem_wdata"},  bus.mem_wdata, 32'd0);
        check({tag, "_mem_mbe"},    32'(bus.mem_mbe), 32'd0);
        check({tag, "_inst_rdata"}, bus.inst_rdata, 32'd0);
        check({tag, "_data_rdata"}, bus.data_rdata, 32'd0);
    endtask

    initial begin
        reset          = 1'b0;
        bus.inst_read  = 1'b0;
        bus.inst_addr  = '0;
        bus.data_read  = 1'b0;
        bus.data_write = 1'b0;
        bus.data_mbe   = '0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        repeat (3) @(posedge clk);
        #3;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        gap(2);

        // Single instruction read with two wait cycles
        mem_wait = 2;
        bus.inst_read = 1'b1;
        bus.inst_addr = 32'h0000_0060;
        exp_mem(1'b0, 32'h60, 32'h0, 4'h0);
        exp_resp(1'b0, 32'h00A0_0093);
        wait_resp(1'b0, 1);
        bus.inst_read = 1'b0;
        gap(2);

        // Both ports held: four data grants, one instruction grant, twice
        mem_wait = 0;
        bus.inst_read = 1'b1;
        bus.inst_addr = 32'h0000_0080;
        bus.data_read = 1'b1;
        bus.data_addr = 32'h0000_0200;
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) begin
                exp_mem(1'b0, 32'h200, 32'h0, 4'h0);
                exp_resp(1'b1, 32'hA5A5_0200);
            end
            exp_mem(1'b0, 32'h80, 32'h0, 4'h0);
            exp_resp(1'b0, 32'hA5A5_0080);
        end
        exp_d_rdata = 32'hA5A5_0200;
        wait_resp(1'b0, 2);
        bus.inst_read = 1'b0;
        bus.data_read = 1'b0;
        gap(2);

        // Partial write; data_rdata must keep the last read value
        bus.data_write = 1'b1;
        bus.data_addr  = 32'h0000_0104;
        bus.data_wdata = 32'hDEAD_BEEF;
        bus.data_mbe   = 4'b0011;
        exp_mem(1'b1, 32'h104, 32'hDEAD_BEEF, 4'b0011);
        exp_resp(1'b1, exp_d_rdata);
        wait_resp(1'b1, 1);
        bus.data_write = 1'b0;
        gap(2);

        // Address changes while the read is in flight
        mem_wait = 3;
        bus.data_read = 1'b1;
        bus.data_addr = 32'h0000_0200;
        exp_mem(1'b0, 32'h200, 32'h0, 4'h0);
        exp_resp(1'b1, 32'hA5A5_0200);
        @(posedge clk);
        #3;
        @(posedge clk);
        #3;
        bus.data_addr = 32'h0000_0300;
        wait_resp(1'b1, 1);
        bus.data_read = 1'b0;
        gap(2);

        // Read and write together is a write
        mem_wait = 1;
        bus.data_read  = 1'b1;
        bus.data_write = 1'b1;
        bus.data_addr  = 32'h0000_0010;
        bus.data_wdata = 32'h1234_5678;
        bus.data_mbe   = 4'hF;
        exp_mem(1'b1, 32'h10, 32'h1234_5678, 4'hF);
        exp_resp(1'b1, exp_d_rdata);
        wait_resp(1'b1, 1);
        bus.data_read  = 1'b0;
        bus.data_write = 1'b0;
        gap(2);

        // Write with no byte enables still completes
        mem_wait = 0;
        bus.data_write = 1'b1;
        bus.data_addr  = 32'h0000_0020;
        bus.data_wdata = 32'hCAFE_F00D;
        bus.data_mbe   = 4'h0;
        exp_mem(1'b1, 32'h20, 32'hCAFE_F00D, 4'h0);
        exp_resp(1'b1, exp_d_rdata);
        wait_resp(1'b1, 1);
        bus.data_write = 1'b0;
        gap(2);

        // Asynchronous reset in the middle of an instruction fetch, then regrant
        mem_wait = 5;
        bus.inst_read = 1'b1;
        bus.inst_addr = 32'h0000_0044;
        exp_mem(1'b0, 32'h44, 32'h0, 4'h0);
        exp_mem(1'b0, 32'h44, 32'h0, 4'h0);
        exp_resp(1'b0, 32'hA5A5_0044);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b1;
        wait_resp(1'b0, 1);
        bus.inst_read = 1'b0;
        gap(5);

        check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
        check("resp_queue_drained", 32'(resp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Responder end of the split instruction/data memory interface driven by the pipeline datapath.
- Accepts independent instruction-fetch and data-access requests and serialises them onto one shared single-port memory/cache interface.
- Returns a one-cycle response pulse with read data to the originating port.
- Sits between the pipeline datapath and the unified cache or memory model.

Parameters:
- MAX_DATA_STREAK, 4: maximum consecutive data grants while an instruction request is pending before the instruction port is forced a grant. Range 1..15.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; DATA_W/8 byte enables.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- inst_read  in  1  instruction read request, held until inst_resp
- inst_addr  in  ADDR_W  instruction address
- inst_resp  out  1  one-cycle response pulse to instruction port
- inst_rdata  out  DATA_W  instruction read data, valid with inst_resp, held afterwards
- data_read  in  1  data read request, held until data_resp
- data_write  in  1  data write request, held until data_resp
- data_mbe  in  DATA_W/8  byte enables for writes
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_resp  out  1  one-cycle response pulse to data port
- data_rdata  out  DATA_W  data read data, valid with data_resp, held afterwards
- mem_read  out  1  shared-port read strobe
- mem_write  out  1  shared-port write strobe
- mem_addr  out  ADDR_W  shared-port address
- mem_wdata  out  DATA_W  shared-port write data
- mem_mbe  out  DATA_W/8  shared-port byte enables
- mem_resp  in  1  shared-port completion, one cycle
- mem_rdata  in  DATA_W  shared-port read data, valid with mem_resp

Behaviour:
- Reset (reset=0, asynchronous):
  - state is IDLE and streak counter is 0.
  - All outputs are 0: resp, rdata, mem strobes, mem_addr, mem_wdata, mem_mbe.
  - An in-flight shared-port transaction is abandoned. Memory side tolerates strobe drop.
- States:
  - IDLE: sample requests; on grant, latch op, addr, wdata and mbe into request register; go to BUSY_I or BUSY_D.
  - BUSY_I / BUSY_D: drive mem_* from the latched request only, never from live inputs. Hold until mem_resp=1. On mem_resp, capture mem_rdata into the granted port's rdata register (reads only) and go to RESP.
  - RESP: pulse inst_resp or data_resp for exactly one cycle; mem strobes are 0. Next state is IDLE.
- Grant rule in IDLE:
  - Data only → data. Instruction only → instruction.
  - Both pending → data, unless streak counter == MAX_DATA_STREAK, in which case instruction.
  - Streak counter: +1 on each data grant while inst_read=1; cleared on any instruction grant; saturates at MAX_DATA_STREAK.
- data_read and data_write both 1: treated as write; read ignored; data_rdata unchanged.
- Write with data_mbe=0 is forwarded unchanged and still gets data_resp.
- data_rdata is unchanged on writes. rdata registers are never cleared except by reset.
- Latency: request seen in IDLE at cycle t → mem strobe at t+1 → mem_resp at t+1+k (k≥0 wait cycles) → port resp at t+2+k. Minimum 2 cycles from request sample to resp pulse.
- Requester may drop or change its request the cycle after resp. The RESP cycle guarantees no duplicate grant of a completed request.
- Requests arriving while not in IDLE wait; no queueing beyond the held request lines.
- Only one mem strobe is ever high; at most one resp is high per cycle.
- mem_resp outside BUSY_* is ignored.

Decomposition:
- Shared package mem_arb_pkg:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D, RESP}
  - arb_op_t enum {OP_READ, OP_WRITE}
  - arb_src_t enum {SRC_INST, SRC_DATA}
  - default MAX_DATA_STREAK constant.
- One natural sub-module, arb_req_reg: the latched request (src, op, addr, wdata, mbe) with load enable and async active-low clear.

Test Plan:
- Single instruction read, inst_addr=0x60, memory returns 0x00A00093 after 2 wait cycles → mem_read for 3 cycles with mem_addr=0x60; inst_resp one cycle later; inst_rdata=0x00A00093; data port idle throughout.
- Data write, addr=0x104, wdata=0xDEADBEEF, mbe=0b0011 → mem_write=1 with identical addr/wdata/mbe; data_resp one pulse; data_rdata unchanged.
- Simultaneous inst_read at 0x80 and data_read at 0x200 held continuously, MAX_DATA_STREAK=4 → grant order D,D,D,D,I; streak counter returns to 0 after the instruction grant.
- Inputs change during BUSY_D (data_addr 0x200→0x300) → mem_addr stays 0x200 until mem_resp.
- data_read=data_write=1 → write issued, mem_read never asserted.
- reset=0 asserted mid-BUSY_I → all outputs 0 immediately, without waiting for clk; after release the same held request is regranted from IDLE and completes normally.
